// File: rtl/cw305_pmul_seq_if.sv
// Bus bundle tying the point-multiplication sequencer to the CW305 register block
// (operand reads, result writes, status) and to the ECC scalar-multiply core.
interface cw305_pmul_seq_if #(
  parameter int pADDR_WIDTH = 3
) ();
  logic                   I_start;
  logic [31:0]            I_k_word;
  logic [31:0]            I_gx_word;
  logic [31:0]            I_gy_word;
  logic [pADDR_WIDTH-1:0] k_addr;
  logic [pADDR_WIDTH-1:0] gx_addr;
  logic [pADDR_WIDTH-1:0] gy_addr;
  logic [pADDR_WIDTH-1:0] rx_addr;
  logic [pADDR_WIDTH-1:0] ry_addr;
  logic                   rx_wren;
  logic                   ry_wren;
  logic [31:0]            O_rx_word;
  logic [31:0]            O_ry_word;
  logic                   O_ready;
  logic                   O_busy;
  logic                   O_done;
  logic                   O_error;

  logic                   core_ld_wr;
  logic [pADDR_WIDTH-1:0] core_ld_addr;
  logic [31:0]            core_ld_k;
  logic [31:0]            core_ld_gx;
  logic [31:0]            core_ld_gy;
  logic                   core_start;
  logic                   core_abort;
  logic                   I_core_done;
  logic [pADDR_WIDTH-1:0] core_rd_addr;
  logic [31:0]            I_core_rx_word;
  logic [31:0]            I_core_ry_word;

  modport master (
    input  I_start, I_k_word, I_gx_word, I_gy_word,
    input  I_core_done, I_core_rx_word, I_core_ry_word,
    output k_addr, gx_addr, gy_addr, rx_addr, ry_addr, rx_wren, ry_wren,
    output O_rx_word, O_ry_word, O_ready, O_busy, O_done, O_error,
    output core_ld_wr, core_ld_addr, core_ld_k, core_ld_gx, core_ld_gy,
    output core_start, core_abort, core_rd_addr
  );

  modport slave (
    output I_start, I_k_word, I_gx_word, I_gy_word,
    output I_core_done, I_core_rx_word, I_core_ry_word,
    input  k_addr, gx_addr, gy_addr, rx_addr, ry_addr, rx_wren, ry_wren,
    input  O_rx_word, O_ry_word, O_ready, O_busy, O_done, O_error,
    input  core_ld_wr, core_ld_addr, core_ld_k, core_ld_gx, core_ld_gy,
    input  core_start, core_abort, core_rd_addr
  );
endinterface

// File: rtl/cw305_pmul_seq.sv
// Sequencer: loads k/Gx/Gy into the ECC core, launches it under a watchdog,
// then copies Rx/Ry back into the register block and reports status.
module cw305_pmul_seq #(
  parameter int pWORDS         = 8,
  parameter int pADDR_WIDTH    = 3,
  parameter int pTIMEOUT_WIDTH = 24
) (
  input logic              crypto_clk,
  input logic              reset_i,
  cw305_pmul_seq_if.master bus
);
  localparam int IDX_W = pADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(pWORDS);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LAST = pADDR_WIDTH'(pWORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_UNLOAD, S_FIN} state_e;

  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          idx_d;
  logic [pTIMEOUT_WIDTH-1:0] wdog_q;
  logic [pADDR_WIDTH-1:0]    src_addr_q;
  logic [pADDR_WIDTH-1:0]    dst_addr_q;
  logic [31:0]               ld_k_q;
  logic                      ld_wr_q;
  logic                      wren_q;
  logic                      core_start_q;
  logic                      done_q;
  logic                      busy_q;
  logic                      ready_q;
  logic                      error_q;

  function automatic logic [pADDR_WIDTH-1:0] sat_addr(input logic [IDX_W-1:0] i);
    if (i >= IDX_LAST) begin
      return ADDR_LAST;
    end else begin
      return i[pADDR_WIDTH-1:0];
    end
  endfunction

  assign idx_d = idx_q + IDX_W'(1);

  // Source/destination addresses are loaded one cycle ahead so they are registered
  // outputs; the write strobe trails the read address by one cycle in LOAD and UNLOAD.
  always_ff @(posedge crypto_clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wdog_q       <= '0;
      src_addr_q   <= '0;
      dst_addr_q   <= '0;
      ld_k_q       <= 32'h0;
      ld_wr_q      <= 1'b0;
      wren_q       <= 1'b0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      error_q      <= 1'b0;
    end else begin
      ld_wr_q      <= 1'b0;
      wren_q       <= 1'b0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.I_start) begin
            state_q    <= S_LOAD;
            idx_q      <= '0;
            src_addr_q <= '0;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          idx_q      <= idx_d;
          src_addr_q <= sat_addr(idx_d);
          dst_addr_q <= idx_q[pADDR_WIDTH-1:0];
          // k arrives combinationally; registering it lines it up with Gx/Gy
          ld_k_q     <= bus.I_k_word;
          if (idx_q == IDX_LAST) begin
            state_q      <= S_START;
            core_start_q <= 1'b1;
          end else begin
            ld_wr_q <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_RUN;
          wdog_q  <= '0;
        end
        S_RUN: begin
          wdog_q <= wdog_q + pTIMEOUT_WIDTH'(1);
          if (bus.I_core_done) begin
            state_q    <= S_UNLOAD;
            idx_q      <= '0;
            src_addr_q <= '0;
          end else if (&wdog_q) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_UNLOAD: begin
          idx_q      <= idx_d;
          src_addr_q <= sat_addr(idx_d);
          dst_addr_q <= idx_q[pADDR_WIDTH-1:0];
          if (idx_q == IDX_LAST) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end else begin
            wren_q <= 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.k_addr       = src_addr_q;
  assign bus.gx_addr      = src_addr_q;
  assign bus.gy_addr      = src_addr_q;
  assign bus.core_rd_addr = src_addr_q;
  assign bus.core_ld_addr = dst_addr_q;
  assign bus.rx_addr      = dst_addr_q;
  assign bus.ry_addr      = dst_addr_q;
  assign bus.core_ld_wr   = ld_wr_q;
  assign bus.core_ld_k    = ld_k_q;
  // Gx/Gy and result words are already registered at their source; gate them to 0 off-strobe
  assign bus.core_ld_gx   = ld_wr_q ? bus.I_gx_word : 32'h0;
  assign bus.core_ld_gy   = ld_wr_q ? bus.I_gy_word : 32'h0;
  assign bus.rx_wren      = wren_q;
  assign bus.ry_wren      = wren_q;
  assign bus.O_rx_word    = wren_q ? bus.I_core_rx_word : 32'h0;
  assign bus.O_ry_word    = wren_q ? bus.I_core_ry_word : 32'h0;
  assign bus.core_start   = core_start_q;
  // Abort must see done in the terminal cycle itself so that done wins
  assign bus.core_abort   = (state_q == S_RUN) && (&wdog_q) && !bus.I_core_done;
  assign bus.O_done       = done_q;
  assign bus.O_busy       = busy_q;
  assign bus.O_ready      = ready_q;
  assign bus.O_error      = error_q;
endmodule

// File: tb/tb_cw305_pmul_seq.sv
// Bench for cw305_pmul_seq: two instances (watchdog width 4 and 8) share directed
// stimulus; a cycle-offset job model plus literal expectations judge every output.
module tb_cw305_pmul_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic start_s;
  logic done_s;
  int   cyc = 0;
  int   lit_s = -1;
  int   n_pass = 0;
  int   n_tot = 0;

  typedef struct packed {
    logic        ld_wr;
    logic [2:0]  ld_addr;
    logic [31:0] ld_k;
    logic [31:0] ld_gx;
    logic [31:0] ld_gy;
    logic [2:0]  k_addr;
    logic [2:0]  gx_addr;
    logic [2:0]  gy_addr;
    logic [2:0]  rd_addr;
    logic        start;
    logic        abort;
    logic        rx_wren;
    logic        ry_wren;
    logic [2:0]  rx_addr;
    logic [2:0]  ry_addr;
    logic [31:0] rx_word;
    logic [31:0] ry_word;
    logic        ready;
    logic        busy;
    logic        done;
    logic        error;
  } obs_t;

  obs_t obs [2];

  // instance 0 uses a 16-cycle watchdog, instance 1 a 256-cycle one
  localparam int TO [2] = '{16, 256};

  function automatic logic [31:0] k_word(input int a);
    return {8'(4 * a + 4), 8'(4 * a + 3), 8'(4 * a + 2), 8'(4 * a + 1)};
  endfunction
  function automatic logic [31:0] gx_word(input int a);
    return 32'hA5A5_0000 + 32'(a);
  endfunction
  function automatic logic [31:0] gy_word(input int a);
    return 32'h5A5A_0000 + 32'(a * 16);
  endfunction
  function automatic logic [31:0] rx_word(input int a);
    return 32'hC0DE_0000 + 32'(a);
  endfunction
  function automatic logic [31:0] ry_word(input int a);
    return 32'hBEEF_0000 + 32'(a * 3);
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int TW = (g == 0) ? 4 : 8;
    cw305_pmul_seq_if #(.pADDR_WIDTH(3)) bus ();
    logic [31:0] gx_r, gy_r, rx_r, ry_r;

    assign bus.I_start        = start_s;
    assign bus.I_core_done    = done_s;
    assign bus.I_k_word       = k_word(int'(bus.k_addr));
    assign bus.I_gx_word      = gx_r;
    assign bus.I_gy_word      = gy_r;
    assign bus.I_core_rx_word = rx_r;
    assign bus.I_core_ry_word = ry_r;

    always @(posedge clk) begin
      gx_r <= gx_word(int'(bus.gx_addr));
      gy_r <= gy_word(int'(bus.gy_addr));
      rx_r <= rx_word(int'(bus.core_rd_addr));
      ry_r <= ry_word(int'(bus.core_rd_addr));
    end

    cw305_pmul_seq #(.pWORDS(8), .pADDR_WIDTH(3), .pTIMEOUT_WIDTH(TW)) u_dut (
      .crypto_clk (clk),
      .reset_i    (rst_n),
      .bus        (bus)
    );

    assign obs[g] = '{ld_wr: bus.core_ld_wr, ld_addr: bus.core_ld_addr, ld_k: bus.core_ld_k,
                      ld_gx: bus.core_ld_gx, ld_gy: bus.core_ld_gy, k_addr: bus.k_addr,
                      gx_addr: bus.gx_addr, gy_addr: bus.gy_addr, rd_addr: bus.core_rd_addr,
                      start: bus.core_start, abort: bus.core_abort, rx_wren: bus.rx_wren,
                      ry_wren: bus.ry_wren, rx_addr: bus.rx_addr, ry_addr: bus.ry_addr,
                      rx_word: bus.O_rx_word, ry_word: bus.O_ry_word, ready: bus.O_ready,
                      busy: bus.O_busy, done: bus.O_done, error: bus.O_error};
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", nm, inst, cyc, act, exp);
    end
  endtask

  // Job model: a job is fixed by its start cycle S and first accepted done cycle D
  int m_s [2] = '{0, 0};
  int m_d [2] = '{-1, -1};
  bit m_act [2];
  bit m_err [2];

  always @(negedge clk) begin : compare
    int c, t, u, e, tl, a;
    bit bz, ld, ldw, unl, wr;
    c = cyc;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0;
        m_err[i] = 1'b0;
        m_d[i]   = -1;
        chk("rst_ready", i, 32'(obs[i].ready), 32'd1);
        chk("rst_busy", i, 32'(obs[i].busy), 32'd0);
        chk("rst_done", i, 32'(obs[i].done), 32'd0);
        chk("rst_error", i, 32'(obs[i].error), 32'd0);
        chk("rst_strobes", i, 32'({obs[i].ld_wr, obs[i].start, obs[i].abort, obs[i].rx_wren, obs[i].ry_wren}), 32'd0);
        chk("rst_addrs", i, 32'({obs[i].k_addr, obs[i].rd_addr, obs[i].ld_addr, obs[i].rx_addr}), 32'd0);
        chk("rst_data", i, obs[i].ld_k | obs[i].ld_gx | obs[i].rx_word | obs[i].ry_word, 32'd0);
      end else begin
        tl = m_s[i] + 10 + TO[i];
        if (m_act[i]) begin
          if (m_d[i] < 0 && c >= m_s[i] + 11 && c <= tl && done_s) m_d[i] = c;
          e = (m_d[i] >= 0) ? m_d[i] + 10 : tl + 1;
          if (c > e) m_act[i] = 1'b0;
        end
        if (!m_act[i] && start_s) begin
          m_act[i] = 1'b1;
          m_s[i]   = c;
          m_d[i]   = -1;
        end
        tl = m_s[i] + 10 + TO[i];
        e  = (m_d[i] >= 0) ? m_d[i] + 10 : tl + 1;
        t  = c - m_s[i];
        u  = c - m_d[i];
        if (m_act[i] && t == 1) m_err[i] = 1'b0;
        if (m_act[i] && m_d[i] < 0 && c == tl + 1) m_err[i] = 1'b1;
        bz  = m_act[i] && t >= 1;
        ld  = m_act[i] && t >= 1 && t <= 9;
        ldw = m_act[i] && t >= 2 && t <= 9;
        unl = m_act[i] && m_d[i] >= 0 && u >= 1 && u <= 9;
        wr  = unl && u >= 2;
        chk("busy", i, 32'(obs[i].busy), 32'(bz));
        chk("ready", i, 32'(obs[i].ready), 32'(!bz));
        chk("error", i, 32'(obs[i].error), 32'(m_err[i]));
        chk("core_start", i, 32'(obs[i].start), 32'(m_act[i] && t == 10));
        chk("core_abort", i, 32'(obs[i].abort), 32'(m_act[i] && m_d[i] < 0 && c == tl));
        chk("done", i, 32'(obs[i].done), 32'(m_act[i] && c == e));
        chk("ld_wr", i, 32'(obs[i].ld_wr), 32'(ldw));
        chk("rx_wren", i, 32'(obs[i].rx_wren), 32'(wr));
        chk("ry_wren", i, 32'(obs[i].ry_wren), 32'(wr));
        if (ld) begin
          a = (t - 1 > 7) ? 7 : t - 1;
          chk("k_addr", i, 32'(obs[i].k_addr), 32'(a));
          chk("gx_addr", i, 32'(obs[i].gx_addr), 32'(a));
          chk("gy_addr", i, 32'(obs[i].gy_addr), 32'(a));
        end
        if (ldw) begin
          chk("ld_addr", i, 32'(obs[i].ld_addr), 32'(t - 2));
          chk("ld_k", i, obs[i].ld_k, k_word(t - 2));
          chk("ld_gx", i, obs[i].ld_gx, gx_word(t - 2));
          chk("ld_gy", i, obs[i].ld_gy, gy_word(t - 2));
        end
        if (unl) begin
          a = (u - 1 > 7) ? 7 : u - 1;
          chk("rd_addr", i, 32'(obs[i].rd_addr), 32'(a));
        end
        if (wr) begin
          chk("rx_addr", i, 32'(obs[i].rx_addr), 32'(u - 2));
          chk("ry_addr", i, 32'(obs[i].ry_addr), 32'(u - 2));
          chk("rx_word", i, obs[i].rx_word, rx_word(u - 2));
          chk("ry_word", i, obs[i].ry_word, ry_word(u - 2));
        end
      end
    end
    // Hand-computed anchors for the nominal job (dut1) and its timeout twin (dut0)
    if (rst_n && lit_s >= 0) begin
      case (c - lit_s)
        2: begin
          chk("lit_ld_k0", 1, obs[1].ld_k, 32'h0403_0201);
          chk("lit_ld_wr_addr0", 1, 32'({obs[1].ld_wr, obs[1].ld_addr}), 32'h8);
        end
        9:  chk("lit_ld_k7", 1, obs[1].ld_k, 32'h201F_1E1D);
        10: chk("lit_core_start", 1, 32'(obs[1].start), 32'd1);
        26: chk("lit_abort", 0, 32'(obs[0].abort), 32'd1);
        27: chk("lit_to_done", 0, 32'(obs[0].done), 32'd1);
        28: chk("lit_to_error", 0, 32'(obs[0].error), 32'd1);
        42: begin
          chk("lit_wren_addr0", 1, 32'({obs[1].rx_wren, obs[1].ry_wren, obs[1].rx_addr}), 32'h18);
          chk("lit_rx0", 1, obs[1].rx_word, 32'hC0DE_0000);
        end
        45: chk("lit_to_error_sticky", 0, 32'(obs[0].error), 32'd1);
        49: chk("lit_rx_addr7", 1, 32'(obs[1].rx_addr), 32'd7);
        50: chk("lit_done", 1, 32'(obs[1].done), 32'd1);
        51: chk("lit_busy_low", 1, 32'(obs[1].busy), 32'd0);
        default: ;
      endcase
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic job_start(output int s);
    @(posedge clk);
    #1;
    start_s = 1'b1;
    done_s  = 1'b0;
    s       = cyc;
    @(posedge clk);
    #1;
    start_s = 1'b0;
  endtask

  task automatic pulse_done(input int c);
    wait_to(c);
    done_s = 1'b1;
    wait_to(c + 1);
    done_s = 1'b0;
  endtask

  initial begin
    int s;
    rst_n   = 1'b0;
    start_s = 1'b0;
    done_s  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // nominal job, done in cycle 40; the 16-cycle instance times out first
    job_start(s);
    lit_s = s;
    pulse_done(s + 40);
    wait_to(s + 60);

    // done lands exactly on the short watchdog's terminal cycle
    job_start(s);
    pulse_done(s + 26);
    wait_to(s + 40);

    // second start while busy is dropped
    job_start(s);
    wait_to(s + 5);
    start_s = 1'b1;
    wait_to(s + 6);
    start_s = 1'b0;
    pulse_done(s + 20);
    wait_to(s + 35);

    // reset pulse in UNLOAD cycle D+4, then a full job
    job_start(s);
    pulse_done(s + 20);
    wait_to(s + 24);
    #1 rst_n = 1'b0;
    #5 rst_n = 1'b1;
    job_start(s);
    pulse_done(s + 30);
    wait_to(s + 45);

    // held-level done, then a start in the first IDLE cycle after FIN
    job_start(s);
    wait_to(s + 40);
    done_s = 1'b1;
    wait_to(s + 50);
    job_start(s);
    pulse_done(s + 15);
    wait_to(s + 30);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
